// File: rtl/grant_code_arbiter.sv
// grant_code_arbiter: four-way round-robin arbiter with registered grant code.
// Optional hold limit compiled in with ARB_HOLD_LIMIT_EN (limit = MAX_HOLD).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[3:0]   in   level-sensitive requests, bit i = requester i
//   grant[3:0] out  one-hot grant, 0 when idle
//   grant_code out  granted index + 1, 0 when no grant
//   busy       out  high while a grant is held
//   timeout    out  one-cycle pulse in the GAP after a forced revoke
module grant_code_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [3:0] grant_code,
   output logic       busy,
   output logic       timeout
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("MAX_HOLD out of range 2..255");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_ptr, w_ptr_nxt;
   logic [1:0] r_idx, w_idx_nxt;
   logic [3:0] r_grant, w_grant_nxt;
   logic [3:0] r_code, w_code_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_timeout, w_timeout_nxt;

   // Rotating priority search starting at r_ptr.
   logic       w_win_vld;
   logic [1:0] w_win_idx;
   logic [1:0] w_cand;

   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = 2'd0;
      w_cand    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_cand = r_ptr + 2'(k);
         if (!w_win_vld && req[w_cand]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_cand;
         end
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [7:0] LP_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] r_cnt, w_cnt_nxt;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_idx_nxt     = r_idx;
      w_grant_nxt   = r_grant;
      w_code_nxt    = r_code;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      w_cnt_nxt     = r_cnt;
`endif
      unique case (r_state)
         S_IDLE, S_GAP: begin
            if (w_win_vld) begin
               w_state_nxt = S_GRANT;
               w_idx_nxt   = w_win_idx;
               w_ptr_nxt   = w_win_idx + 2'd1;
               w_grant_nxt = 4'b0001 << w_win_idx;
               w_code_nxt  = {2'b00, w_win_idx} + 4'd1;
               w_busy_nxt  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
               w_cnt_nxt   = 8'd0;
`endif
            end else begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = 4'b0000;
               w_code_nxt  = 4'b0000;
               w_busy_nxt  = 1'b0;
            end
         end
         S_GRANT: begin
            // A release on the limit cycle wins over the revoke,
            // so no timeout is flagged in that case.
            if (!req[r_idx]) begin
               w_state_nxt = S_GAP;
               w_grant_nxt = 4'b0000;
               w_code_nxt  = 4'b0000;
               w_busy_nxt  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt   = S_GAP;
               w_grant_nxt   = 4'b0000;
               w_code_nxt    = 4'b0000;
               w_busy_nxt    = 1'b0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
`endif
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 4'b0000;
            w_code_nxt  = 4'b0000;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_idx     <= 2'd0;
         r_grant   <= 4'b0000;
         r_code    <= 4'b0000;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_idx     <= w_idx_nxt;
         r_grant   <= w_grant_nxt;
         r_code    <= w_code_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= 8'd0;
      else        r_cnt <= w_cnt_nxt;
   end
   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
   logic w_unused;
   assign w_unused = r_timeout;
`endif

   assign grant      = r_grant;
   assign grant_code = r_code;
   assign busy       = r_busy;

endmodule

// File: tb/tb_grant_code_arbiter.sv
// Directed bench for grant_code_arbiter with a scoreboard queue of expected
// outputs; covers both builds of ARB_HOLD_LIMIT_EN (MAX_HOLD = 4 here).
module tb_grant_code_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic [3:0] grant_code;
   logic       busy;
   logic       timeout;

   always #5 clk = ~clk;

   grant_code_arbiter #(.MAX_HOLD(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .grant      (grant),
      .grant_code (grant_code),
      .busy       (busy),
      .timeout    (timeout)
   );

   typedef struct {
      logic [3:0] code;
      logic       to;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errs    = 0;

   task automatic chk();
      exp_t       e;
      logic [3:0] eg;
      logic       eb;
      vectors++;
      assert (sb.size() != 0) else begin
         errs++;
         $error("FAIL sb_empty: no expected entry");
      end
      if (sb.size() == 0) return;
      e  = sb.pop_front();
      eg = (e.code == 4'd0) ? 4'b0000 : (4'b0001 << (e.code - 4'd1));
      eb = (e.code != 4'd0);
      vectors++;
      assert (grant_code === e.code) else begin
         errs++;
         $error("FAIL %s grant_code got %b exp %b", e.tag, grant_code, e.code);
      end
      vectors++;
      assert (grant === eg) else begin
         errs++;
         $error("FAIL %s grant got %b exp %b", e.tag, grant, eg);
      end
      vectors++;
      assert (busy === eb) else begin
         errs++;
         $error("FAIL %s busy got %b exp %b", e.tag, busy, eb);
      end
      vectors++;
      assert (timeout === e.to) else begin
         errs++;
         $error("FAIL %s timeout got %b exp %b", e.tag, timeout, e.to);
      end
   endtask

   task automatic now(input logic [3:0] code, input logic to,
                      input string tag);
      sb.push_back('{code: code, to: to, tag: tag});
      chk();
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] code,
                       input logic to, input string tag);
      req = r;
      sb.push_back('{code: code, to: to, tag: tag});
      @(posedge clk);
      #1;
      chk();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      #12;
      now(4'b0000, 1'b0, "reset");
      rst_n = 1'b1;

      // Round robin, each owner holds two cycles then drops.
      step(4'b1111, 4'b0001, 1'b0, "rr_g0a");
      step(4'b1111, 4'b0001, 1'b0, "rr_g0b");
      step(4'b1110, 4'b0000, 1'b0, "rr_gap0");
      step(4'b1111, 4'b0010, 1'b0, "rr_g1a");
      step(4'b1111, 4'b0010, 1'b0, "rr_g1b");
      step(4'b1101, 4'b0000, 1'b0, "rr_gap1");
      step(4'b1111, 4'b0011, 1'b0, "rr_g2a");
      step(4'b1111, 4'b0011, 1'b0, "rr_g2b");
      step(4'b1011, 4'b0000, 1'b0, "rr_gap2");
      step(4'b1111, 4'b0100, 1'b0, "rr_g3a");
      step(4'b1111, 4'b0100, 1'b0, "rr_g3b");
      step(4'b0111, 4'b0000, 1'b0, "rr_gap3");
      step(4'b1111, 4'b0001, 1'b0, "rr_wrap");
      step(4'b0000, 4'b0000, 1'b0, "rr_rel");
      step(4'b0000, 4'b0000, 1'b0, "rr_idle");

      // Single requester 2; held below the hold limit when compiled in.
`ifdef ARB_HOLD_LIMIT_EN
      for (int i = 0; i < 3; i++)
         step(4'b0100, 4'b0011, 1'b0, "single");
`else
      for (int i = 0; i < 5; i++)
         step(4'b0100, 4'b0011, 1'b0, "single");
`endif
      step(4'b0000, 4'b0000, 1'b0, "single_gap");
      step(4'b0000, 4'b0000, 1'b0, "single_idle");

      // Requesters 0 and 1 held high; pointer is at 3 so 0 wins.
`ifdef ARB_HOLD_LIMIT_EN
      for (int i = 0; i < 4; i++)
         step(4'b0011, 4'b0001, 1'b0, "hold_g0");
      step(4'b0011, 4'b0000, 1'b1, "hold_revoke");
      step(4'b0011, 4'b0010, 1'b0, "hold_next");
`else
      for (int i = 0; i < 300; i++)
         step(4'b0011, 4'b0001, 1'b0, "nohold_g0");
      step(4'b0010, 4'b0000, 1'b0, "nohold_rel");
      step(4'b0010, 4'b0010, 1'b0, "nohold_next");
`endif

      // Asynchronous reset while requester 1 holds the grant.
      #3;
      rst_n = 1'b0;
      #1;
      now(4'b0000, 1'b0, "async_rst");
      #1;
      rst_n = 1'b1;
      step(4'b1111, 4'b0001, 1'b0, "ptr_reset");

      // Owner drops on the very cycle the limit would hit: plain release.
      step(4'b1111, 4'b0001, 1'b0, "edge_c2");
      step(4'b1111, 4'b0001, 1'b0, "edge_c3");
      step(4'b1111, 4'b0001, 1'b0, "edge_c4");
      step(4'b1110, 4'b0000, 1'b0, "edge_rel");
      step(4'b0000, 4'b0000, 1'b0, "final_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/grant_code_arbiter.md
# grant_code_arbiter

Round-robin arbiter sharing one resource among four requesters. Grants are issued as a registered 4-bit code (requester index + 1: 4'b0001..4'b0100, 4'b0000 = none). This matches the input convention of the team's BCD-to-number index decoder, so the code drives that decoder directly. A dead cycle separates consecutive grants, and an optional hold limit prevents any requester from monopolising the resource.

## Interface
- MAX_HOLD, 16: maximum consecutive GRANT cycles per grant when the hold limit is compiled in; legal range 2..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request vector; bit i is requester i; level-sensitive.
- grant  out  4  one-hot grant; 4'b0000 when idle.
- grant_code  out  4  granted index + 1 (4'b0001..4'b0100); 4'b0000 when no grant.
- busy  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked; constant 0 when the hold limit is compiled out.

## Operation
- State machine:
  - IDLE: arbitrate; any req bit set -> GRANT.
  - GRANT: owner's req low -> GAP. Hold limit reached -> GAP, with timeout pulsed.
  - GAP: exactly one cycle with grant = 0; arbitrates like IDLE, going to GRANT if any req is set, else IDLE.
- Arbitration: 2-bit pointer ptr. Search starts at ptr and proceeds ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit wins.
- On each new grant to index i, ptr <= i+1 mod 4 (3 wraps to 0).
- Only the owner's req bit matters during GRANT. Other req changes are ignored until arbitration.
- grant, grant_code and busy are registered and mutually consistent every cycle:
  - grant_code = {1'b0, idx} + 1.
  - busy = |grant.
- Hold counter (8 bits):
  - Cleared on entry to GRANT.
  - Increments each GRANT cycle.
  - At count == MAX_HOLD-1 with the owner's req still high: revoke.
- Reset state: IDLE, ptr = 0, counter = 0; grant = 4'b0000, grant_code = 4'b0000, busy = 0, timeout = 0.
- Reset mid-grant drops the grant immediately (asynchronous). No timeout pulse is produced.

## Timing
- Grant latency: req sampled at edge N in IDLE or GAP -> grant visible after edge N (registered), i.e. one cycle after req is presented.
- Release: owner's req low before edge N -> grant = 0 after edge N (GAP). Next grant earliest after edge N+1.
- Minimum gap between grants to different owners, or re-grant to the same owner: 1 cycle.
- Hold limit: grant is high for exactly MAX_HOLD cycles. timeout is high in the first GAP cycle only.
- Simultaneous events:
  - Owner drops req on the same edge the limit is reached: treated as a normal release, timeout = 0.
  - All four req bits set continuously: grants rotate 0,1,2,3,0…, each followed by one GAP cycle.
- Revoked owner with req still high: it is still eligible, but ptr has advanced past it, so it is served last in rotation.

## Configuration
- ARB_HOLD_LIMIT_EN defined: hold counter and forced revocation as above; timeout is functional.
- ARB_HOLD_LIMIT_EN undefined: no hold counter. A grant persists while the owner's req stays high; timeout is tied to 0 and MAX_HOLD is ignored.

## Test plan
- Reset: rst_n = 0 with req = 4'b1111 -> grant = 4'b0000, grant_code = 4'b0000, busy = 0, timeout = 0. After release, the first grant goes to requester 0 (grant_code = 4'b0001) one cycle later.
- Single requester: req = 4'b0100 held 5 cycles, then dropped -> grant_code = 4'b0011 for 5 cycles, then 4'b0000 for 1 cycle, then IDLE.
- Round robin: req = 4'b1111 with each owner releasing after 2 cycles -> grant_code sequence 0001, 0010, 0011, 0100, 0001, each separated by one 0000 cycle.
- Hold limit (macro on, MAX_HOLD = 4): req = 4'b0011 held high -> req0 granted for exactly 4 cycles, timeout = 1 in the GAP cycle, then req1 granted (grant_code = 4'b0010).
- Hold limit (macro off): same stimulus -> req0 holds grant indefinitely (checked for 300 cycles); timeout never asserts.
- Async reset mid-grant: rst_n pulsed low between edges during a grant_code = 4'b0010 grant -> outputs go to 0 before the next edge; ptr = 0 afterwards.
